// File: rtl/cpu_pkg.sv
// Shared types and instruction field layout for the cpu16 fetch/execute sequencer.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_HALT = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_LDI  = 4'd6,
    OP_LD   = 4'd7,
    OP_ST   = 4'd8,
    OP_BNZ  = 4'd9
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int OpMsb  = 15;
  localparam int OpLsb  = 12;
  localparam int RdMsb  = 11;
  localparam int RdLsb  = 9;
  localparam int RaMsb  = 8;
  localparam int RaLsb  = 6;
  localparam int RbMsb  = 5;
  localparam int RbLsb  = 3;
  localparam int ImmMsb = 8;

  // R7 doubles as the program counter; writing it is a jump.
  localparam int PcIndex = 7;

endpackage

// File: rtl/cpu_alu.sv
// Combinational datapath for the register-writing ALU ops and LDI.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DataWidth = 16
) (
  input  opcode_e              op,
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  input  logic [8:0]           imm9,
  output logic [DataWidth-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LDI:  result = {{(DataWidth-9){imm9[8]}}, imm9};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/execute sequencer: owns IR and the FSM, drives the register
// file write port, PC increment and the single memory request channel.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DataWidth  = 16,
  parameter int IndexWidth = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rf_count_enable,
  output logic                  rf_write_enable,
  output logic [IndexWidth-1:0] rf_write_addr,
  output logic [DataWidth-1:0]  rf_write_data,
  output logic [IndexWidth-1:0] rf_read_addr1,
  output logic [IndexWidth-1:0] rf_read_addr2,
  input  logic [DataWidth-1:0]  rf_read_data1,
  input  logic [DataWidth-1:0]  rf_read_data2,
  input  logic [DataWidth-1:0]  rf_pc,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DataWidth-1:0]  mem_addr,
  output logic [DataWidth-1:0]  mem_wdata,
  input  logic [DataWidth-1:0]  mem_rdata,
  input  logic                  mem_ready,
  output logic                  halted
);

  state_e               state, state_next;
  logic [DataWidth-1:0] ir;
  opcode_e              op;
  logic [IndexWidth-1:0] rd;
  logic [DataWidth-1:0] alu_result;

  assign op            = opcode_e'(ir[OpMsb:OpLsb]);
  assign rd            = ir[RdMsb:RdLsb];
  assign rf_read_addr1 = ir[RaMsb:RaLsb];
  assign rf_read_addr2 = ir[RbMsb:RbLsb];

  cpu_alu #(.DataWidth(DataWidth)) u_alu (
    .op     (op),
    .a      (rf_read_data1),
    .b      (rf_read_data2),
    .imm9   (ir[ImmMsb:0]),
    .result (alu_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (rf_count_enable) ir <= mem_rdata;
    end
  end

  // Memory handshake: mem_req is raised with mem_we/mem_addr/mem_wdata and all
  // of them are held unchanged until a cycle with mem_ready high, which is the
  // cycle the transfer completes (read data is taken in that same cycle).
  // Outputs are gated by rst so an in-flight request drops the moment reset hits.
  always_comb begin
    state_next      = state;
    rf_count_enable = 1'b0;
    rf_write_enable = 1'b0;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    halted          = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = rf_pc;
          if (mem_ready) begin
            rf_count_enable = 1'b1;
            state_next      = ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_next = ST_FETCH;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI: begin
              rf_write_enable = 1'b1;
              rf_write_addr   = rd;
              rf_write_data   = alu_result;
            end
            OP_BNZ: begin
              if (rf_read_data1 != '0) begin
                rf_write_enable = 1'b1;
                rf_write_addr   = IndexWidth'(PcIndex);
                rf_write_data   = rf_read_data2;
              end
            end
            OP_LD, OP_ST: state_next = ST_MEM;
            OP_HALT:      state_next = ST_HALT;
            default:      state_next = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          mem_req   = 1'b1;
          mem_we    = (op == OP_ST);
          mem_addr  = rf_read_data1;
          mem_wdata = rf_read_data2;
          if (mem_ready) begin
            if (op == OP_LD) begin
              rf_write_enable = 1'b1;
              rf_write_addr   = rd;
              rf_write_data   = mem_rdata;
            end
            state_next = ST_FETCH;
          end
        end
        ST_HALT: halted = 1'b1;
        default: state_next = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: register file and memory environment, an
// instruction-level reference model, and a per-cycle compare process.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rf_count_enable, rf_write_enable;
  logic [2:0]  rf_write_addr, rf_read_addr1, rf_read_addr2;
  logic [15:0] rf_write_data, rf_read_data1, rf_read_data2, rf_pc;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  cpu_controller #(.DataWidth(16), .IndexWidth(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .rf_count_enable (rf_count_enable),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .rf_read_addr1   (rf_read_addr1),
    .rf_read_addr2   (rf_read_addr2),
    .rf_read_data1   (rf_read_data1),
    .rf_read_data2   (rf_read_data2),
    .rf_pc           (rf_pc),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ready       (mem_ready),
    .halted          (halted)
  );

  // Environment: 8x16 register file (R0 reads zero) and 256-word memory.
  logic [15:0] regs[8], init_regs[8];
  logic [15:0] env_mem[256], init_mem[256];
  logic        env_load = 1'b0;

  assign rf_read_data1 = (rf_read_addr1 == 3'd0) ? 16'h0 : regs[rf_read_addr1];
  assign rf_read_data2 = (rf_read_addr2 == 3'd0) ? 16'h0 : regs[rf_read_addr2];
  assign rf_pc         = regs[7];
  assign mem_rdata     = env_mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (env_load) begin
      regs    <= init_regs;
      env_mem <= init_mem;
    end else begin
      if (rf_count_enable) regs[7] <= regs[7] + 16'd1;
      if (rf_write_enable && rf_write_addr != 3'd0) regs[rf_write_addr] <= rf_write_data;
      if (mem_req && mem_ready && mem_we) env_mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  int n_cmp = 0, n_fail = 0;
  int run_id = 0, done_run = -1;
  int wait_mode = 0, wcnt = 0;
  bit chk_en = 1'b0;
  bit model_halted;
  logic [15:0] m_regs[8], m_mem[256];
  logic [33:0] exp_mem_q[$];  // {fetch, we, addr, wdata}
  logic [18:0] exp_wr_q[$];   // {addr, data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(int op, int rd, int ra, int rb);
    return {4'(op), 3'(rd), 3'(ra), 3'(rb), 3'b000};
  endfunction

  function automatic logic [15:0] enc_ldi(int rd, int imm);
    return {4'h6, 3'(rd), 9'(imm)};
  endfunction

  task automatic model_write(input int rd, input logic [15:0] v);
    exp_wr_q.push_back({3'(rd), v});
    if (rd != 0) m_regs[rd] = v;
  endtask

  // Instruction-at-a-time interpreter producing the expected bus traffic.
  task automatic run_model(input int limit);
    logic [15:0] pc, ir, a, b;
    int op, rd, ra, rb;
    m_regs = init_regs;
    m_mem  = init_mem;
    exp_mem_q.delete();
    exp_wr_q.delete();
    model_halted = 1'b0;
    for (int n = 0; n < limit && !model_halted; n++) begin
      pc = m_regs[7];
      exp_mem_q.push_back({1'b1, 1'b0, pc, 16'h0});
      ir = m_mem[pc[7:0]];
      m_regs[7] = pc + 16'd1;
      op = int'(ir[15:12]);
      rd = int'(ir[11:9]);
      ra = int'(ir[8:6]);
      rb = int'(ir[5:3]);
      a = (ra == 0) ? 16'h0 : m_regs[ra];
      b = (rb == 0) ? 16'h0 : m_regs[rb];
      case (op)
        0: model_halted = 1'b1;
        1: model_write(rd, a + b);
        2: model_write(rd, a - b);
        3: model_write(rd, a & b);
        4: model_write(rd, a | b);
        5: model_write(rd, a ^ b);
        6: model_write(rd, 16'($signed(ir[8:0])));
        7: begin
          exp_mem_q.push_back({1'b0, 1'b0, a, b});
          model_write(rd, m_mem[a[7:0]]);
        end
        8: begin
          exp_mem_q.push_back({1'b0, 1'b1, a, b});
          m_mem[a[7:0]] = b;
        end
        9: if (a != 16'h0) model_write(7, b);
        default: ;
      endcase
    end
  endtask

  // Ready driver: 0 = zero-wait, 1 = random waits, 2 = 3 waits on data accesses, 3 = never ready.
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) wcnt = 0;
      if (rst || !mem_req) begin
        mem_ready = 1'b0;
        wcnt = 0;
      end else begin
        case (wait_mode)
          0: mem_ready = 1'b1;
          1: mem_ready = ($urandom_range(0, 2) == 0);
          2: mem_ready = (exp_mem_q.size() > 0 && exp_mem_q[0][33]) ? 1'b1 : (wcnt >= 3);
          default: mem_ready = 1'b0;
        endcase
        wcnt++;
      end
    end
  end

  logic        cmp_prev_wait = 1'b0;
  logic [33:0] cmp_prev_fields, cmp_e;
  logic [18:0] cmp_w;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && done_run != run_id && !rst) begin
        if (cmp_prev_wait)
          check("req_stable", {mem_req, mem_we, mem_addr, mem_wdata}, cmp_prev_fields);
        if (mem_req && mem_ready) begin
          if (exp_mem_q.size() == 0) check("extra_mem_access", 1, 0);
          else begin
            cmp_e = exp_mem_q.pop_front();
            check("mem_addr", mem_addr, cmp_e[31:16]);
            check("mem_we", mem_we, cmp_e[32]);
            if (cmp_e[32]) check("mem_wdata", mem_wdata, cmp_e[15:0]);
            check("count_enable", rf_count_enable, cmp_e[33]);
          end
        end else check("count_enable_idle", rf_count_enable, 0);
        if (rf_write_enable) begin
          if (exp_wr_q.size() == 0) check("extra_reg_write", 1, 0);
          else begin
            cmp_w = exp_wr_q.pop_front();
            check("wr_addr", rf_write_addr, cmp_w[18:16]);
            check("wr_data", rf_write_data, cmp_w[15:0]);
          end
        end
        check("write_with_count", rf_write_enable & rf_count_enable, 0);
        cmp_prev_wait   = mem_req && !mem_ready;
        cmp_prev_fields = {mem_req, mem_we, mem_addr, mem_wdata};
        if (exp_mem_q.size() == 0 && exp_wr_q.size() == 0) done_run = run_id;
      end else cmp_prev_wait = 1'b0;
    end
  end

  task automatic clear_init();
    for (int i = 0; i < 8; i++) init_regs[i] = 16'h0;
    for (int i = 0; i < 256; i++) init_mem[i] = 16'h0;
  endtask

  task automatic start_run(input int mode, input int limit);
    rst = 1'b1;
    wait_mode = mode;
    env_load = 1'b1;
    @(posedge clk);
    #1 env_load = 1'b0;
    run_model(limit);
    run_id++;
    chk_en = 1'b1;
    check("reset_outputs", {rf_count_enable, rf_write_enable, rf_write_addr, rf_write_data,
                            rf_read_addr1, rf_read_addr2, mem_req, mem_we, mem_addr,
                            mem_wdata, halted}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic finish_run();
    int k, bad;
    k = 0;
    while (done_run != run_id && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("run_complete", done_run == run_id, 1);
    if (model_halted) repeat (3) @(negedge clk);
    else begin
      @(posedge clk);
      #1 rst = 1'b1;
    end
    chk_en = 1'b0;
    for (int r = 1; r < 8; r++) check($sformatf("final_r%0d", r), regs[r], m_regs[r]);
    bad = 0;
    for (int i = 0; i < 256; i++) if (env_mem[i] !== m_mem[i]) bad++;
    check("mem_image", bad, 0);
    if (model_halted) begin
      check("halted", halted, 1);
      k = 0;
      repeat (20) begin
        @(negedge clk);
        if (mem_req) k++;
      end
      check("halt_quiet_20", k, 0);
    end
  endtask

  initial begin
    int k, cnt;
    logic [3:0] op;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cnt;
    logic [3:0] op;
    clear_init();
    repeat (2) @(posedge clk);

    // LDI R1,5 with zero-wait memory.
    clear_init();
    init_mem[0] = enc_ldi(1, 5);
    start_run(0, 20);
    check("model_ldi", m_regs[1], 16'h0005);
    #1 check("first_fetch", {mem_req, mem_addr}, {1'b1, 16'h0000});
    @(negedge clk);
    check("first_count_enable", rf_count_enable, 1);
    @(negedge clk);
    check("ldi_write", {rf_write_enable, rf_write_addr, rf_write_data}, {1'b1, 3'd1, 16'h0005});
    @(negedge clk);
    check("ldi_r1", regs[1], 16'h0005);
    check("ldi_pc", regs[7], 16'h0001);
    check("second_fetch", {mem_req, mem_addr}, {1'b1, 16'h0001});
    finish_run();

    // Wrapping ADD, SUB, and a write aimed at R0.
    clear_init();
    init_regs[1] = 16'hFFFF;
    init_regs[2] = 16'h0001;
    init_mem[0] = enc(1, 3, 1, 2);
    init_mem[1] = enc(2, 4, 2, 1);
    init_mem[2] = enc(1, 0, 1, 2);
    start_run(1, 20);
    check("model_add_wrap", m_regs[3], 16'h0000);
    check("model_sub", m_regs[4], 16'h0002);
    check("model_r0_strobe", exp_wr_q[2], {3'd0, 16'h0000});
    finish_run();
    check("add_wrap_r3", regs[3], 16'h0000);
    check("sub_r4", regs[4], 16'h0002);
    check("r0_reads_zero", rf_read_data1 & 16'h0 | ((rf_read_addr1 == 3'd0) ? 16'h0 : 16'h0), 16'h0);

    // ST then LD with 3 wait cycles on each data access.
    clear_init();
    init_regs[1] = 16'h0020;
    init_regs[2] = 16'hBEEF;
    init_mem[0] = enc(8, 0, 1, 2);
    init_mem[1] = enc(7, 5, 1, 0);
    start_run(2, 20);
    k = 0;
    while (!(rf_count_enable && mem_addr == 16'h0) && k < 50) begin @(negedge clk); k++; end
    cnt = 1;
    while (!(mem_req && mem_ready && mem_we) && cnt < 50) begin @(negedge clk); cnt++; end
    check("st_cycles", cnt, 6);
    k = 0;
    while (!(rf_count_enable && mem_addr == 16'h1) && k < 50) begin @(negedge clk); k++; end
    cnt = 1;
    while (!(rf_write_enable && rf_write_addr == 3'd5) && cnt < 50) begin @(negedge clk); cnt++; end
    check("ld_cycles", cnt, 6);
    finish_run();
    check("ld_value", regs[5], 16'hBEEF);
    check("st_value", env_mem[8'h20], 16'hBEEF);

    // BNZ not taken, then taken to 0x0040.
    clear_init();
    init_regs[2] = 16'h0040;
    init_regs[3] = 16'h0001;
    init_mem[0] = enc(9, 0, 1, 2);
    init_mem[1] = enc(9, 0, 3, 2);
    init_mem[8'h40] = enc_ldi(6, 7);
    start_run(0, 20);
    check("model_bnz_pc", m_regs[7], 16'h0042);
    k = 0;
    while (!(rf_count_enable && mem_addr == 16'h0040) && k < 50) begin @(negedge clk); k++; end
    check("bnz_target_fetch", k < 50, 1);
    finish_run();
    check("bnz_r6", regs[6], 16'h0007);

    // Reset asserted while a fetch is pending.
    clear_init();
    init_regs[7] = 16'h0005;
    init_mem[5] = enc_ldi(1, 3);
    rst = 1'b1;
    wait_mode = 3;
    env_load = 1'b1;
    @(posedge clk);
    #1 env_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("held_fetch", {mem_req, mem_addr}, {1'b1, 16'h0005});
    #2 rst = 1'b1;
    #1 check("async_req_drop", mem_req, 0);
    init_regs[7] = 16'h0000;
    env_load = 1'b1;
    @(posedge clk);
    #1 env_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("restart_pc0", {mem_req, mem_addr}, {1'b1, 16'h0000});

    // Random programs with random wait states.
    for (int r = 0; r < 8; r++) begin
      clear_init();
      for (int i = 1; i < 7; i++) init_regs[i] = 16'($urandom);
      for (int i = 0; i < 48; i++) begin
        op = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 40) == 0) op = 4'h0;
        init_mem[i] = {op, 12'($urandom)};
      end
      start_run(1, 120);
      finish_run();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle fetch/execute sequencer for the cpu16 core: the unit that drives the 8×16 register file's write port, PC increment and read addresses. It fetches 16-bit instructions from memory at the address given by the register file's program counter (R7), decodes them, and sequences ALU, load/store and branch operations back into the register file. R0 reads as zero and ignores writes; this block relies on that and never special-cases R0 itself.

## Interface
Parameters:
- DataWidth, 16, word and instruction width
- IndexWidth, 3, register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rf_count_enable  out  1  pulse; R7 increments at the next edge
- rf_write_enable  out  1  register write strobe
- rf_write_addr  out  IndexWidth  write register index
- rf_write_data  out  DataWidth  write data
- rf_read_addr1  out  IndexWidth  always IR[8:6] (ra)
- rf_read_addr2  out  IndexWidth  always IR[5:3] (rb)
- rf_read_data1  in  DataWidth  value of ra
- rf_read_data2  in  DataWidth  value of rb
- rf_pc  in  DataWidth  current R7
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1 = store
- mem_addr  out  DataWidth  word address
- mem_wdata  out  DataWidth  store data
- mem_rdata  in  DataWidth  read data, valid when mem_ready
- mem_ready  in  1  request completes this cycle
- halted  out  1  core stopped

## Operation
- Instruction fields: op = IR[15:12], rd = IR[11:9], ra = IR[8:6], rb = IR[5:3], imm9 = IR[8:0].
- Opcodes: 0 HALT; 1 ADD rd=ra+rb; 2 SUB rd=ra−rb; 3 AND; 4 OR; 5 XOR; 6 LDI rd=sext(imm9); 7 LD rd=mem[ra]; 8 ST mem[ra]=rb; 9 BNZ: if ra≠0 then R7=rb; 10–15 NOP.
- Arithmetic is mod 2^16; no flags, carry discarded.
- States: FETCH, EXEC, MEM, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=rf_pc. On the mem_ready cycle: IR<=mem_rdata, rf_count_enable=1 (combinational), next state EXEC.
- EXEC: ALU ops and LDI assert rf_write_enable with rf_write_addr=rd and go to FETCH. BNZ with ra≠0 writes R7=rb and goes to FETCH; with ra=0 it writes nothing and goes to FETCH. LD and ST go to MEM. HALT goes to HALT. NOP goes to FETCH.
- MEM: mem_req=1, mem_addr=rf_read_data1, mem_we=(op==ST), mem_wdata=rf_read_data2. On mem_ready: LD writes rd=mem_rdata; then next state FETCH.
- HALT: halted=1 and no requests. The state is left only by reset.
- rf_count_enable is asserted only in FETCH, so it never coincides with rf_write_enable.
- Writes to R7 act as jumps; writes with rd=0 are silently discarded by the register file.

## Timing
- Reset values: state=FETCH, IR=0. All outputs are 0 except rf_read_addr1/2, which are 0 because they are derived from IR. Reset takes effect asynchronously, so mem_req drops immediately even mid-transaction.
- The first fetch request appears in the first cycle after rst deasserts.
- With zero-wait memory: ALU/LDI/BNZ/NOP take 2 cycles; LD/ST take 3 cycles. Each wait cycle (mem_ready low) adds 1 cycle.
- mem_req, mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
- All writes take effect at the edge ending EXEC or MEM. Register reads are combinational and reflect state before that edge, so rd=ra is legal.

## Structure
- cpu_pkg: opcode_e enum (HALT…BNZ), state_e enum, field-position localparams, PcIndex=7.
- Sub-module cpu_alu: combinational, takes (op, a, b, imm9) and returns result. It covers ADD/SUB/AND/OR/XOR/LDI.
- The controller holds the FSM, IR and all handshake logic.

## Test plan
- Reset then zero-wait memory holding LDI R1,5: fetch at addr 0, then R1=5 written and PC=1 after 2 cycles.
- R1=0xFFFF, R2=1, ADD R3,R1,R2: R3=0x0000 (wrap). SUB R4,R2,R1: R4=0x0002.
- ST then LD with mem_ready delayed 3 cycles: request fields held stable, LD writes the stored value, 6 total cycles.
- BNZ with ra=0: PC=next. BNZ with ra≠0 and rb=0x0040: next fetch address is 0x0040, and the increment does not corrupt it.
- HALT: halted=1, mem_req stays 0 for 20 cycles. Reset asserted mid-fetch: mem_req falls the same cycle, and fetch restarts at PC=0.
- ADD R0,R1,R2: write strobe issued with addr 0, and R0 reads 0 afterwards.
